// File: rtl/rwb_pkg.sv
// rwb_pkg: shared definitions for the register write buffer.
//   DATA_W_DEF / ADDR_W_DEF : default data and register-index widths
//   R0_IDX                  : index of the hardwired-zero register
//   rwb_entry_t             : one buffered write, {addr, data}, at default widths
package rwb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int R0_IDX     = 0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } rwb_entry_t;

endpackage

// File: rtl/rwb_match.sv
// rwb_match: youngest-first lookup over the occupied entries of the write buffer.
// Ports:
//   ent_addr, ent_data : entry storage, indexed by slot
//   rd_ptr             : slot of the oldest (head) entry
//   count              : number of occupied entries starting at rd_ptr
//   lk_addr            : register index being looked up
//   hit                : some occupied entry targets lk_addr
//   data               : value of the youngest such entry, 0 on a miss
module rwb_match
  import rwb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PTR_W  = 2,
  parameter int CNT_W  = 3
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [PTR_W-1:0]             rd_ptr,
  input  logic [CNT_W-1:0]             count,
  input  logic [ADDR_W-1:0]            lk_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  // Walk from the head (oldest) toward the tail; a later match overwrites an
  // earlier one, so the youngest matching entry is what remains.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) && (lk_addr != ADDR_W'(R0_IDX)) &&
          (ent_addr[rd_ptr + PTR_W'(k)] == lk_addr)) begin
        hit  = 1'b1;
        data = ent_data[rd_ptr + PTR_W'(k)];
      end
    end
  end

endmodule

// File: rtl/reg_write_buffer.sv
// reg_write_buffer: in-order FIFO of register writes sitting between the
// datapath write-back and the register file write port, with optional
// forwarding lookups for operands being decoded.
// Optional feature macro: RWB_FORWARD_EN (lookup ports active when defined,
// tied to zero otherwise).
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   wr_valid/wr_addr/wr_data      : write-back request, accepted when wr_ready
//   wr_ready                      : a slot is free (registered occupancy only)
//   rf_stall                      : register file port busy this cycle
//   rf_write_signal/addr/data     : head entry presented to the register file
//   lk_addr_x, lk_hit_x, lk_data_x: two forwarding lookups
//   count                         : occupied entries
// Valid/ready: a request transfers on a rising edge where wr_valid and
// wr_ready are both high; writes to R0 transfer but are dropped.
module reg_write_buffer
  import rwb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic                       rf_stall,
  output logic                       rf_write_signal,
  output logic [ADDR_W-1:0]          rf_write_addr,
  output logic [DATA_W-1:0]          rf_write_data,
  input  logic [ADDR_W-1:0]          lk_addr_1,
  input  logic [ADDR_W-1:0]          lk_addr_2,
  output logic                       lk_hit_1,
  output logic                       lk_hit_2,
  output logic [DATA_W-1:0]          lk_data_1,
  output logic [DATA_W-1:0]          lk_data_2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic                         push;
  logic                         pop;
  logic                         not_empty;

  // wr_ready looks only at registered count, so a pop while full frees the
  // slot one cycle later.
  always_comb begin
    not_empty       = (count != '0);
    wr_ready        = (count != CNT_W'(DEPTH));
    rf_write_signal = not_empty && !rf_stall;
    pop             = rf_write_signal;
    push            = wr_valid && wr_ready && (wr_addr != ADDR_W'(R0_IDX));
    rf_write_addr   = not_empty ? ent_addr[rd_ptr] : '0;
    rf_write_data   = not_empty ? ent_data[rd_ptr] : '0;
  end

  // Storage has no reset; count gating hides stale slots.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= wr_addr;
      ent_data[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef RWB_FORWARD_EN
  // Lookups see registered entries only, so a same-cycle request is not visible.
  rwb_match #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PTR_W(PTR_W), .CNT_W(CNT_W)
  ) u_match_1 (
    .ent_addr(ent_addr), .ent_data(ent_data), .rd_ptr(rd_ptr), .count(count),
    .lk_addr(lk_addr_1), .hit(lk_hit_1), .data(lk_data_1)
  );

  rwb_match #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PTR_W(PTR_W), .CNT_W(CNT_W)
  ) u_match_2 (
    .ent_addr(ent_addr), .ent_data(ent_data), .rd_ptr(rd_ptr), .count(count),
    .lk_addr(lk_addr_2), .hit(lk_hit_2), .data(lk_data_2)
  );
`else
  // Forwarding disabled: lookup indices are accepted but ignored.
  logic unused_lk;
  assign unused_lk = ^{lk_addr_1, lk_addr_2};
  assign lk_hit_1  = 1'b0;
  assign lk_hit_2  = 1'b0;
  assign lk_data_1 = '0;
  assign lk_data_2 = '0;
`endif

endmodule
